lzd_shift_sequencer: RTL
========================

Name: lzd_shift_sequencer

Overview:
Parametrised successor to the fixed 5-bit counter-vs-LZD comparator. It sequences a normalisation shift: on start it latches a leading-zero count, then asserts shift_en once per cycle while an internal counter is below that count. It sits between the leading-zero detector and the shift register in the normaliser datapath. It replaces the external counter plus 5-bit less-than pair with one self-contained FSM, adding a busy/done handshake and a shift clamp.

Parameters:
CNT_W, 5, width of counter, lzd_in and shift_count.
MAX_SHIFT, 31, upper clamp on the latched shift amount; must be <= 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
lzd_in  input  CNT_W  leading-zero count from LZD; sampled on the start edge.
shift_en  output  1  shift-register enable; one pulse per required shift.
busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive.
done  output  1  single-cycle completion pulse.
shift_count  output  CNT_W  current counter value (shifts issued so far).
abort  input  1  present only with LZD_SEQ_ABORT_EN (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, target_r=0; shift_en=0, busy=0, done=0, shift_count=0.
- States: IDLE, SHIFT, DONE.
- IDLE: with start=1 at edge k:
  - target_r <= min(lzd_in, MAX_SHIFT) (unsigned compare); counter <= 0.
  - Next state is SHIFT if the clamped value != 0, otherwise DONE.
- SHIFT:
  - shift_en = (counter < target_r), unsigned CNT_W compare, decoded from state and registers (no combinational path from inputs).
  - Each cycle counter <= counter+1.
  - When counter+1 == target_r, next state is DONE.
- DONE: done=1, shift_en=0, counter holds the final value (== target_r); next state is IDLE.
- Latency for clamped amount T:
  - shift_en high in cycles k+1..k+T, exactly T pulses.
  - done in cycle k+T+1.
  - T=0 gives done at k+1 with no shift_en pulse.
- No wrap-around: counter stops at target_r <= 2^CNT_W-1, so it never overflows.
- start while busy=1 is ignored; lzd_in is not re-sampled.
- start held high continuously: a new run is accepted in the IDLE cycle after DONE, so back-to-back runs have a one-cycle gap.
- shift_count holds its last value in IDLE until the next accepted start clears it.
- rst asserted mid-run: outputs drop to reset values immediately, and no done pulse is emitted for the aborted run.

Optional Feature:
Macro LZD_SEQ_ABORT_EN.
- Defined: an abort input port exists. abort=1 in SHIFT forces next state DONE on that edge.
  - shift_en is 0 in that cycle.
  - done still pulses once; shift_count reports the shifts actually issued.
  - abort is ignored in IDLE and DONE. abort and start together in IDLE: start wins.
- Not defined: the port is absent and a run always completes T shifts.

Test Plan:
- Reset mid-run: start, lzd_in=7; rst=1 after 3 shift_en pulses -> all outputs 0 immediately; no done; next start with lzd_in=2 gives 2 pulses.
- Nominal: start, lzd_in=3 at edge k -> shift_en high k+1..k+3; done at k+4; shift_count=3; busy high k+1..k+4.
- Zero: start, lzd_in=0 -> done at k+1; no shift_en; shift_count=0.
- Clamp: MAX_SHIFT=8, lzd_in=20 -> exactly 8 pulses; done at k+9. CNT_W=6, MAX_SHIFT=63, lzd_in=63 -> 63 pulses, no wrap.
- Busy ignore and back-to-back: start lzd_in=5, second start with lzd_in=1 during SHIFT is ignored (5 pulses). start held high gives the next run accepted in the IDLE cycle after done.
- With LZD_SEQ_ABORT_EN: lzd_in=10, abort on the 4th SHIFT cycle -> 3 pulses; done the next cycle; shift_count=3.

Source files
------------

// File: rtl/lzd_shift_sequencer.sv
// Normalisation shift sequencer: latches a clamped leading-zero count on start and
// issues one shift_en per cycle until that many shifts are done. Optional abort via LZD_SEQ_ABORT_EN.
module lzd_shift_sequencer #(
  parameter int CNT_W     = 5,
  parameter int MAX_SHIFT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] lzd_in,
`ifdef LZD_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SHIFT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] clamp_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             abort_s;

`ifdef LZD_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign clamp_s   = (lzd_in > MAX_C) ? MAX_C : lzd_in;
  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Next-state logic; the counter stops at target_q so it never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = clamp_s;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = (clamp_s != {CNT_W{1'b0}}) ? ST_SHIFT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort_s) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == target_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and latched target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      target_q <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Outputs decode registered state only (abort gates shift_en when that feature is built in).
  assign shift_en    = (state_q == ST_SHIFT) && (cnt_q < target_q) && !abort_s;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign shift_count = cnt_q;

endmodule
